// File: rtl/bus_decoder.sv
// Address decoder and single-outstanding read-response router for N_DEV slave devices.
// Define BUS_DECODER_FAULT_EN to build the sticky unmapped-access fault capture.
module bus_decoder #(
    parameter int unsigned N_DEV = 4,
    parameter int unsigned DATA_W = 32,
    parameter logic [N_DEV*32-1:0] DEV_BASE = {N_DEV{32'h0}},
    parameter logic [N_DEV*32-1:0] DEV_MASK = {N_DEV{32'hF000_0000}},
    parameter logic [N_DEV*3-1:0] DEV_LAT = {N_DEV{3'd1}},
    localparam int unsigned NB = DATA_W / 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    req_i,
    input  logic [31:0]             addr_i,
    input  logic [DATA_W-1:0]       write_data_i,
    input  logic [NB-1:0]           write_mask_i,
    output logic                    busy_o,
    output logic                    rsp_valid_o,
    output logic [DATA_W-1:0]       read_data_o,
    output logic [N_DEV-1:0]        dev_sel_o,
    output logic [DATA_W-1:0]       dev_write_data_o,
    output logic [N_DEV*NB-1:0]     dev_write_mask_o,
    input  logic [N_DEV*DATA_W-1:0] dev_read_data_i,
    input  logic                    fault_clr_i,
    output logic                    fault_o,
    output logic [31:0]             fault_addr_o,
    output logic [7:0]              fault_count_o
);

    localparam int unsigned IdxW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    typedef enum logic {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            rsp_q, rsp_d;
    logic            unm_q, unm_d;

    logic            hit;
    logic [IdxW-1:0] hit_idx;
    logic [2:0]      hit_lat;
    logic            accept;
    logic            is_read;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int d = N_DEV - 1; d >= 0; d--) begin
            if ((addr_i & DEV_MASK[d*32 +: 32]) == DEV_BASE[d*32 +: 32]) begin
                hit     = 1'b1;
                hit_idx = IdxW'(d);
            end
        end
    end

    always_comb begin
        dev_sel_o = '0;
        for (int unsigned d = 0; d < N_DEV; d++) begin
            dev_sel_o[d] = hit && (hit_idx == IdxW'(d));
        end
    end

    assign hit_lat = DEV_LAT[int'(hit_idx)*3 +: 3];
    assign busy_o  = (state_q == StWait);
    assign accept  = req_i && !busy_o;
    assign is_read = (write_mask_i == '0);

    assign dev_write_data_o = write_data_i;

    always_comb begin
        dev_write_mask_o = '0;
        for (int unsigned d = 0; d < N_DEV; d++) begin
            if (reset_n_i && accept && !is_read && dev_sel_o[d]) begin
                dev_write_mask_o[d*NB +: NB] = write_mask_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unm_d   = unm_q;
        rsp_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && is_read) begin
                    idx_d = hit_idx;
                    unm_d = !hit;
                    // Unmapped reads and single-cycle devices answer without waiting.
                    if (!hit || hit_lat <= 3'd1) begin
                        rsp_d = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = hit_lat - 3'd1;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rsp_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            rsp_q   <= 1'b0;
            unm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rsp_q   <= rsp_d;
            unm_q   <= unm_d;
        end
    end

    assign rsp_valid_o = rsp_q;

    always_comb begin
        read_data_o = '0;
        if (rsp_q && !unm_q) begin
            read_data_o = dev_read_data_i[int'(idx_q)*DATA_W +: DATA_W];
        end
    end

`ifdef BUS_DECODER_FAULT_EN
    logic        fault_q;
    logic [31:0] fault_addr_q;
    logic [7:0]  fault_cnt_q;
    logic        unm_acc;

    assign unm_acc = accept && !hit;

    // Clear has priority over a fault arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || fault_clr_i) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            fault_cnt_q  <= '0;
        end else if (unm_acc) begin
            if (fault_cnt_q != 8'hFF) begin
                fault_cnt_q <= fault_cnt_q + 8'd1;
            end
            if (!fault_q) begin
                fault_q      <= 1'b1;
                fault_addr_q <= addr_i;
            end
        end
    end

    assign fault_o       = fault_q;
    assign fault_addr_o  = fault_addr_q;
    assign fault_count_o = fault_cnt_q;
`else
    logic unused_fault_clr;

    assign unused_fault_clr = fault_clr_i;
    assign fault_o          = 1'b0;
    assign fault_addr_o     = '0;
    assign fault_count_o    = '0;
`endif

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_bus_decoder;

`ifdef BUS_DECODER_FAULT_EN
    localparam bit FaultEn = 1'b1;
`else
    localparam bit FaultEn = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         req_i;
    logic [31:0]  addr_i;
    logic [31:0]  write_data_i;
    logic [3:0]   write_mask_i;
    logic         busy_o;
    logic         rsp_valid_o;
    logic [31:0]  read_data_o;
    logic [3:0]   dev_sel_o;
    logic [31:0]  dev_write_data_o;
    logic [15:0]  dev_write_mask_o;
    logic [127:0] dev_read_data_i;
    logic         fault_clr_i;
    logic         fault_o;
    logic [31:0]  fault_addr_o;
    logic [7:0]   fault_count_o;

    logic [31:0]  dev_rd [4];

    assign dev_read_data_i = {dev_rd[3], dev_rd[2], dev_rd[1], dev_rd[0]};

    always #5 clk_i = ~clk_i;

    bus_decoder #(
        .N_DEV   (4),
        .DATA_W  (32),
        .DEV_BASE({32'hFF00_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .DEV_MASK({32'hFFFF_FFFF, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
        .DEV_LAT ({3'd3, 3'd2, 3'd1, 3'd1})
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .req_i           (req_i),
        .addr_i          (addr_i),
        .write_data_i    (write_data_i),
        .write_mask_i    (write_mask_i),
        .busy_o          (busy_o),
        .rsp_valid_o     (rsp_valid_o),
        .read_data_o     (read_data_o),
        .dev_sel_o       (dev_sel_o),
        .dev_write_data_o(dev_write_data_o),
        .dev_write_mask_o(dev_write_mask_o),
        .dev_read_data_i (dev_read_data_i),
        .fault_clr_i     (fault_clr_i),
        .fault_o         (fault_o),
        .fault_addr_o    (fault_addr_o),
        .fault_count_o   (fault_count_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Region table as the address map describes it.
    int unsigned m_base [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'hFF00_0000};
    int unsigned m_mask [4] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_FFFF};
    int          m_lat  [4] = '{1, 1, 2, 3};

    function automatic int decode(input logic [31:0] a);
        for (int d = 0; d < 4; d++) begin
            if ((a & m_mask[d]) == m_base[d]) return d;
        end
        return -1;
    endfunction

    // Model state: the cycle number on which the pending read answers, and its source.
    int          cyc      = 1;
    int          pend_due = 0;
    int          pend_dev = -1;
    bit          started  = 1'b0;
    bit          mf       = 1'b0;
    logic [31:0] ma       = '0;
    int          mc       = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            begin
                int          d;
                bit          e_busy, e_rsp, acc;
                logic [31:0] e_data;
                logic [15:0] e_wm;
                logic [3:0]  e_sel;
                d      = decode(addr_i);
                e_busy = pend_due > cyc;
                e_rsp  = pend_due == cyc;
                acc    = req_i && !e_busy;
                e_data = (e_rsp && pend_dev >= 0) ? dev_rd[pend_dev] : 32'h0;
                e_sel  = (d >= 0) ? 4'(1 << d) : 4'h0;
                e_wm   = 16'h0;
                if (reset_n_i && acc && write_mask_i != 4'h0 && d >= 0) begin
                    e_wm = 16'(write_mask_i) << (4 * d);
                end
                if (started) begin
                    chk("m_busy", busy_o, e_busy);
                    chk("m_rsp_valid", rsp_valid_o, e_rsp);
                    chk("m_read_data", read_data_o, e_data);
                    chk("m_dev_sel", dev_sel_o, e_sel);
                    chk("m_wmask", dev_write_mask_o, e_wm);
                    chk("m_wdata", dev_write_data_o, write_data_i);
                    chk("m_fault", fault_o, FaultEn ? mf : 1'b0);
                    chk("m_fault_addr", fault_addr_o, FaultEn ? ma : 32'h0);
                    chk("m_fault_count", fault_count_o, FaultEn ? 32'(mc) : 32'h0);
                end
                if (!reset_n_i) begin
                    started  = 1'b1;
                    pend_due = 0;
                    mf       = 1'b0;
                    ma       = '0;
                    mc       = 0;
                end else begin
                    if (acc && write_mask_i == 4'h0) begin
                        pend_due = cyc + ((d < 0) ? 1 : m_lat[d]);
                        pend_dev = d;
                    end
                    if (fault_clr_i) begin
                        mf = 1'b0;
                        ma = '0;
                        mc = 0;
                    end else if (acc && d < 0) begin
                        if (mc < 255) mc++;
                        if (!mf) begin
                            mf = 1'b1;
                            ma = addr_i;
                        end
                    end
                end
                cyc++;
            end
        end
    end

    task automatic drive(input bit r, input logic [31:0] a, input logic [3:0] m);
        req_i        = r;
        addr_i       = a;
        write_mask_i = m;
        write_data_i = $urandom;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    initial begin
        reset_n_i   = 1'b0;
        fault_clr_i = 1'b0;
        for (int i = 0; i < 4; i++) dev_rd[i] = 32'h0;
        drive(1'b0, 32'h0, 4'h0);
        step();
        step();
        reset_n_i = 1'b1;
        neg();
        chk("rst_busy", busy_o, 32'h0);
        chk("rst_rsp", rsp_valid_o, 32'h0);
        chk("rst_fault_count", fault_count_o, 32'h0);
        step();

        // Single-cycle read from dev1.
        dev_rd[1] = 32'hCAFE_F00D;
        dev_rd[3] = 32'h3333_3333;
        drive(1'b1, 32'h1000_0040, 4'h0);
        neg();
        chk("t1_sel", dev_sel_o, 32'h2);
        step();
        drive(1'b0, 32'h0, 4'h0);
        neg();
        chk("t1_rsp", rsp_valid_o, 32'h1);
        chk("t1_data", read_data_o, 32'hCAFE_F00D);
        chk("t1_busy", busy_o, 32'h0);
        step();
        neg();
        chk("t1_rsp_gone", rsp_valid_o, 32'h0);
        chk("t1_data_zero", read_data_o, 32'h0);
        step();

        // Three-cycle read from dev3; requests while busy are ignored.
        drive(1'b1, 32'hFF00_0000, 4'h0);
        step();
        drive(1'b1, 32'h1000_0000, 4'h0);
        neg();
        chk("t2_busy1", busy_o, 32'h1);
        chk("t2_rsp1", rsp_valid_o, 32'h0);
        step();
        neg();
        chk("t2_busy2", busy_o, 32'h1);
        step();
        neg();
        chk("t2_rsp3", rsp_valid_o, 32'h1);
        chk("t2_data3", read_data_o, 32'h3333_3333);
        chk("t2_busy3", busy_o, 32'h0);
        step();
        drive(1'b0, 32'h0, 4'h0);
        neg();
        chk("t2_rsp4", rsp_valid_o, 32'h1);
        chk("t2_data4", read_data_o, 32'hCAFE_F00D);
        step();

        // Write to dev2.
        drive(1'b1, 32'h2000_0004, 4'b0011);
        neg();
        chk("t3_wmask", dev_write_mask_o, 32'h0300);
        chk("t3_rsp", rsp_valid_o, 32'h0);
        step();
        drive(1'b0, 32'h0, 4'h0);
        neg();
        chk("t3_no_rsp", rsp_valid_o, 32'h0);
        step();

        // Unmapped write then read, saturation, then clear colliding with a fault.
        drive(1'b1, 32'h3000_0000, 4'hF);
        neg();
        chk("t4_wmask", dev_write_mask_o, 32'h0);
        chk("t4_sel", dev_sel_o, 32'h0);
        step();
        drive(1'b1, 32'h4000_0000, 4'h0);
        step();
        drive(1'b0, 32'h0, 4'h0);
        neg();
        chk("t4_rsp", rsp_valid_o, 32'h1);
        chk("t4_data", read_data_o, 32'h0);
        chk("t4_fault", fault_o, FaultEn ? 32'h1 : 32'h0);
        chk("t4_fault_addr", fault_addr_o, FaultEn ? 32'h3000_0000 : 32'h0);
        chk("t4_fault_count", fault_count_o, FaultEn ? 32'd2 : 32'h0);
        step();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'h5000_0000 + 32'(i), 4'h0);
            step();
        end
        drive(1'b0, 32'h0, 4'h0);
        neg();
        chk("t4_sat", fault_count_o, FaultEn ? 32'd255 : 32'h0);
        chk("t4_addr_kept", fault_addr_o, FaultEn ? 32'h3000_0000 : 32'h0);
        step();
        drive(1'b1, 32'h6000_0000, 4'hF);
        fault_clr_i = 1'b1;
        step();
        fault_clr_i = 1'b0;
        drive(1'b0, 32'h0, 4'h0);
        neg();
        chk("t4_clr_fault", fault_o, 32'h0);
        chk("t4_clr_addr", fault_addr_o, 32'h0);
        chk("t4_clr_count", fault_count_o, 32'h0);
        step();

        // Reset cancels an outstanding dev2 read and gates write masks.
        drive(1'b1, 32'h2000_0000, 4'h0);
        step();
        drive(1'b0, 32'h0, 4'h0);
        reset_n_i = 1'b0;
        neg();
        chk("t5_busy_pre", busy_o, 32'h1);
        step();
        drive(1'b1, 32'h0000_0010, 4'hF);
        neg();
        chk("t5_rsp", rsp_valid_o, 32'h0);
        chk("t5_busy", busy_o, 32'h0);
        chk("t5_data", read_data_o, 32'h0);
        chk("t5_wmask", dev_write_mask_o, 32'h0);
        chk("t5_sel", dev_sel_o, 32'h1);
        step();
        reset_n_i = 1'b1;
        drive(1'b0, 32'h0, 4'h0);
        neg();
        chk("t5_rsp_after", rsp_valid_o, 32'h0);
        step();

        // Randomized traffic; the model process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a;
            for (int k = 0; k < 4; k++) dev_rd[k] = $urandom;
            case ($urandom_range(0, 5))
                0: a = {4'h0, 28'($urandom)};
                1: a = {4'h1, 28'($urandom)};
                2: a = {4'h2, 28'($urandom)};
                3: a = 32'hFF00_0000;
                4: a = {4'($urandom_range(3, 14)), 28'($urandom)};
                default: a = 32'hFF00_0000 ^ (32'h1 << $urandom_range(0, 23));
            endcase
            drive(($urandom % 10) < 7, a, ($urandom % 2) ? 4'h0 : 4'($urandom));
            fault_clr_i = ($urandom % 50) == 0;
            reset_n_i   = ($urandom % 100) != 0;
            step();
        end
        reset_n_i   = 1'b1;
        fault_clr_i = 1'b0;
        drive(1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
